// File: rtl/uart_word_packer.sv
// Packs the UART receiver's byte strobes into 32-bit words on a valid/ready output.
// Partial words are discarded after an idle timeout. Dropped words are counted in DropCnt.
module uart_word_packer #(
    parameter int unsigned BIG_ENDIAN     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 52000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic [31:0] Word,
    output logic        WordValid,
    input  logic        WordReady,
    output logic [1:0]  ByteCnt,
    output logic        Overrun,
    output logic        Timeout,
    output logic [7:0]  DropCnt
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      asm_q, asm_d, asm_shift;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             commit, load, xfer;

    always_comb begin
        asm_shift = (BIG_ENDIAN != 0) ? {asm_q[23:0], RxData} : {RxData, asm_q[31:8]};
        commit    = RxValid && (byte_cnt_q == 2'd3);
        xfer      = word_valid_q && WordReady;
        // An accepting consumer frees the output slot in the same cycle: no bubble.
        load      = commit && (!word_valid_q || WordReady);
        overrun_d = commit && !load;
        timeout_d = TO_EN && (byte_cnt_q != 2'd0) && !RxValid && (to_cnt_q == TO_LAST);

        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        if (RxValid) begin
            asm_d      = asm_shift;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end else if (timeout_d) begin
            asm_d      = '0;
            byte_cnt_d = 2'd0;
        end

        if (RxValid || (byte_cnt_q == 2'd0) || timeout_d) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + CNT_ONE;
        end

        word_d       = word_q;
        word_valid_d = word_valid_q;
        if (load) begin
            word_d       = asm_shift;
            word_valid_d = 1'b1;
        end else if (xfer) begin
            word_valid_d = 1'b0;
        end

        drop_cnt_d = drop_cnt_q;
        if ((overrun_d || timeout_d) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            asm_q        <= '0;
            byte_cnt_q   <= 2'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            drop_cnt_q   <= 8'd0;
            to_cnt_q     <= '0;
        end else begin
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            drop_cnt_q   <= drop_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign Word      = word_q;
    assign WordValid = word_valid_q;
    assign ByteCnt   = byte_cnt_q;
    assign Overrun   = overrun_q;
    assign Timeout   = timeout_q;
    assign DropCnt   = drop_cnt_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: big- and little-endian instances share stimulus and are
// compared every cycle against a byte-queue reference model.
module tb_uart_word_packer;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        word_ready = 1'b0;

    logic [31:0] be_word, le_word;
    logic        be_wv, le_wv, be_ovr, le_ovr, be_to, le_to;
    logic [1:0]  be_bc, le_bc;
    logic [7:0]  be_drop, le_drop;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  part[$];
    int          idle;
    logic [31:0] e_word_be, e_word_le;
    bit          e_wv, e_ovr, e_to;
    int          e_drop;

    always #5 clk = ~clk;

    uart_word_packer #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut_be (
        .Clk(clk), .Rst(rst), .RxData(rx_data), .RxValid(rx_valid),
        .Word(be_word), .WordValid(be_wv), .WordReady(word_ready),
        .ByteCnt(be_bc), .Overrun(be_ovr), .Timeout(be_to), .DropCnt(be_drop)
    );

    uart_word_packer #(.BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut_le (
        .Clk(clk), .Rst(rst), .RxData(rx_data), .RxValid(rx_valid),
        .Word(le_word), .WordValid(le_wv), .WordReady(word_ready),
        .ByteCnt(le_bc), .Overrun(le_ovr), .Timeout(le_to), .DropCnt(le_drop)
    );

    function automatic logic [89:0] obs();
        return {be_word, le_word, be_wv, be_bc, be_ovr, be_to, be_drop,
                le_wv, le_bc, le_ovr, le_to, le_drop};
    endfunction

    function automatic logic [89:0] expv();
        logic [1:0] bc;
        logic [7:0] dc;
        bc = 2'(part.size());
        dc = 8'(e_drop);
        return {e_word_be, e_word_le, e_wv, bc, e_ovr, e_to, dc,
                e_wv, bc, e_ovr, e_to, dc};
    endfunction

    task automatic model_clear();
        part.delete();
        idle = 0;
        e_word_be = '0;
        e_word_le = '0;
        e_wv = 0;
        e_ovr = 0;
        e_to = 0;
        e_drop = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, sample #1 after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        bit full;
        bit xfer;
        logic [31:0] wb, wl;
        rx_valid = v;
        rx_data = d;
        word_ready = r;
        xfer = e_wv && r;
        full = 0;
        wb = '0;
        wl = '0;
        e_ovr = 0;
        e_to = 0;
        if (v) begin
            part.push_back(d);
            idle = 0;
            if (part.size() == 4) begin
                full = 1;
                wb = {part[0], part[1], part[2], part[3]};
                wl = {part[3], part[2], part[1], part[0]};
                part.delete();
            end
        end else if (part.size() != 0) begin
            idle++;
            if (idle == TO) begin
                e_to = 1;
                part.delete();
                idle = 0;
            end
        end
        if (full && (!e_wv || r)) begin
            e_word_be = wb;
            e_word_le = wl;
            e_wv = 1;
        end else if (full) begin
            e_ovr = 1;
        end else if (xfer) begin
            e_wv = 0;
        end
        if ((e_ovr || e_to) && e_drop < 255) e_drop++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Overrun and Timeout can never coincide.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (be_ovr && be_to) begin
                miscompares++;
                $display("FAIL pulse_overlap: Overrun=%b Timeout=%b, required not both", be_ovr, be_to);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs() !== 90'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h want 0", obs());
        end
        rst = 1'b0;
        model_clear();
        step(0, 8'h00, 0);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_basic();
        logic [7:0] b [4] = '{8'h82, 8'h92, 8'hAA, 8'hBA};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, b[i], 1);
            vectors++;
            if (obs() !== expv() || be_bc !== 2'((i + 1) % 4)) begin
                miscompares++;
                $display("FAIL basic_byte%0d: got %h want %h", i, obs(), expv());
            end
        end
        vectors++;
        if (be_word !== 32'h8292AABA || !be_wv || le_word !== 32'hBAAA9282 || !le_wv) begin
            miscompares++;
            $display("FAIL basic_word: be=%h le=%h, required 8292aaba/baaa9282", be_word, le_word);
        end
        step(0, 8'h00, 1);
        vectors++;
        if (obs() !== expv() || be_wv !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_one_cycle: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_backpressure();
        int novr = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0);
            if (be_ovr) novr++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL bp_byte%0d: got %h want %h", i, obs(), expv());
            end
        end
        step(0, 8'h00, 0);
        vectors++;
        if (be_word !== 32'h01020304 || novr != 1 || be_drop !== 8'd1 || !be_wv) begin
            miscompares++;
            $display("FAIL bp_hold: word=%h ovr=%0d drop=%0d, required 01020304/1/1",
                     be_word, novr, be_drop);
        end
        step(0, 8'h00, 1);
        vectors++;
        if (obs() !== expv() || be_wv !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_back_to_back();
        int nwv = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(i < 12, 8'($urandom_range(0, 255)), 1);
            if (be_wv) nwv++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got %h want %h", i, obs(), expv());
            end
        end
        vectors++;
        if (nwv != 3 || be_drop !== 8'd0) begin
            miscompares++;
            $display("FAIL b2b_count: words=%0d drop=%0d, required 3/0", nwv, be_drop);
        end
    endtask

    task automatic test_timeout();
        int nto = 0;
        int at = -1;
        do_reset();
        step(1, 8'hAA, 1);
        step(1, 8'hBB, 1);
        for (int k = 1; k <= 25; k++) begin
            step(0, 8'h00, 1);
            if (be_to) begin
                nto++;
                at = k;
            end
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL timeout_idle%0d: got %h want %h", k, obs(), expv());
            end
        end
        vectors++;
        if (nto != 1 || at != int'(TO) || be_bc !== 2'd0 || be_drop !== 8'd1) begin
            miscompares++;
            $display("FAIL timeout_pulse: count=%0d at=%0d bc=%0d, required 1/%0d/0",
                     nto, at, be_bc, TO);
        end
        step(1, 8'h11, 1);
        step(1, 8'h22, 1);
        step(1, 8'h33, 1);
        step(1, 8'h44, 1);
        vectors++;
        if (be_word !== 32'h11223344 || !be_wv || obs() !== expv()) begin
            miscompares++;
            $display("FAIL timeout_recover: got %h, required 11223344", be_word);
        end
        // A byte landing on the expiry cycle keeps the partial word alive.
        do_reset();
        nto = 0;
        step(1, 8'hAA, 1);
        step(1, 8'hBB, 1);
        for (int k = 1; k < int'(TO); k++) begin
            step(0, 8'h00, 1);
            if (be_to) nto++;
        end
        step(1, 8'hCC, 1);
        if (be_to) nto++;
        vectors++;
        if (nto != 0 || be_bc !== 2'd3 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL timeout_race: timeouts=%0d bc=%0d, required 0/3", nto, be_bc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i), 0);
        vectors++;
        if (!be_wv || be_bc !== 2'd2 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL rstmid_setup: got %h want %h", obs(), expv());
        end
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs() !== 90'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h want 0", obs());
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== 90'd0) begin
            miscompares++;
            $display("FAIL rstmid_held: got %h want 0", obs());
        end
        rst = 1'b0;
        model_clear();
        step(1, 8'hA1, 1);
        step(1, 8'hB2, 1);
        step(1, 8'hC3, 1);
        step(1, 8'hD4, 1);
        vectors++;
        if (be_word !== 32'hA1B2C3D4 || le_word !== 32'hD4C3B2A1 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL rstmid_word: be=%h le=%h, required a1b2c3d4/d4c3b2a1", be_word, le_word);
        end
    endtask

    task automatic test_random();
        int pv = 50;
        int pr = 50;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                pv = int'($urandom_range(0, 3)) * 33;
                pr = int'($urandom_range(0, 4)) * 25;
            end
            step($urandom_range(0, 99) < pv, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < pr);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
